pio_edge_irq_multi: RTL



---
 rtl/pio_edge_irq_multi.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pio_edge_irq_multi.sv
// pio_edge_irq_multi: Avalon-MM input PIO with per-bit edge capture and irq.
// Define PIO_DEBOUNCE_EN to insert a per-bit debounce filter before edge detect.
module pio_edge_irq_multi #(
   parameter int               WIDTH           = 8,
   parameter int               SYNC_STAGES     = 2,
   parameter logic [WIDTH-1:0] RISE_RESET      = '0,
   parameter logic [WIDTH-1:0] FALL_RESET      = '1,
   parameter int               DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] f_d;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] set_bits;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] wdata;
   logic             wr;
   logic [31:0]      rd_mux;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt_q [WIDTH];

   // f follows s only after s has disagreed with it long enough
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         f <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == f[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               f[i]     <= s[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset_n)
         f <= '0;
      else
         f <= s;
   end
`endif

   assign wr       = chipselect & ~write_n;
   assign wdata    = writedata[WIDTH-1:0];
   assign set_bits = (f & ~f_d & rise_en) | (~f & f_d & fall_en);
   assign clr_bits = (wr && address == 3'd3) ? wdata : '0;
   assign irq      = |(capture & irq_mask);

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux = 32'(f);
         3'd1:    rd_mux = 32'(rise_en);
         3'd2:    rd_mux = 32'(irq_mask);
         3'd3:    rd_mux = 32'(capture);
         3'd4:    rd_mux = 32'(fall_en);
         3'd5:    rd_mux = 32'(WIDTH);
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         f_d      <= '0;
         rise_en  <= RISE_RESET;
         fall_en  <= FALL_RESET;
         irq_mask <= '0;
         capture  <= '0;
         readdata <= '0;
      end else begin
         f_d      <= f;
         // a new edge beats a same-cycle clear so no event is lost
         capture  <= set_bits | (capture & ~clr_bits);
         readdata <= rd_mux;
         unique case (1'b1)
            (wr && address == 3'd1): rise_en  <= wdata;
            (wr && address == 3'd2): irq_mask <= wdata;
            (wr && address == 3'd4): fall_en  <= wdata;
            default: ;
         endcase
      end
   end

endmodule
